// File: rtl/wb_chip_bus_if.sv
// Host-side Wishbone bundle for the chip backdoor interconnect.
// The master modport is the host; the slave modport is the interconnect.
interface wb_chip_bus_if;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_cyc_i;
  logic        wb_strobe_i;
  logic        wb_we_i;
  logic [31:0] wb_data_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_addr_i,
    output wb_data_i,
    output wb_cyc_i,
    output wb_strobe_i,
    output wb_we_i,
    input  wb_data_o,
    input  wb_ack_o,
    input  wb_err_o
  );

  modport slave (
    input  wb_addr_i,
    input  wb_data_i,
    input  wb_cyc_i,
    input  wb_strobe_i,
    input  wb_we_i,
    output wb_data_o,
    output wb_ack_o,
    output wb_err_o
  );
endinterface

// File: rtl/wb_chip_bus.sv
// Registered Wishbone backdoor interconnect: one host master to NUM_ROMS ROM
// and NUM_RAMS RAM chip backdoor ports. One transfer outstanding at a time.
//
// Optional feature macro: WB_BUS_TIMEOUT_EN
//   defined   - a REQ that sees no selected ack for TIMEOUT_CYCLES cycles
//               ends with a bus error.
//   undefined - REQ waits for ack or host abort indefinitely.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for host cyc & strobe; latches address/data/we
// REQ   | s_cyc_o and one slave strobe high, waiting for its ack
// RESP  | single-cycle wb_ack_o or wb_err_o to the host
module wb_chip_bus #(
  parameter int NUM_ROMS       = 1,
  parameter int NUM_RAMS       = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  wb_chip_bus_if.slave             host,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_data_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic [NUM_ROMS-1:0]      rom_strobe_o,
  output logic [NUM_RAMS-1:0]      ram_strobe_o,
  input  logic [32*NUM_ROMS-1:0]   rom_data_i,
  input  logic [NUM_ROMS-1:0]      rom_ack_i,
  input  logic [32*NUM_RAMS-1:0]   ram_data_i,
  input  logic [NUM_RAMS-1:0]      ram_ack_i
);

  if (NUM_ROMS < 1 || NUM_ROMS > 16 || NUM_RAMS < 1 || NUM_RAMS > 16 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("wb_chip_bus: parameter out of legal range");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic                we_q;
  logic                cyc_q;
  logic [NUM_ROMS-1:0] rom_stb_q;
  logic [NUM_RAMS-1:0] ram_stb_q;
  logic                ack_q;
  logic                err_q;
  logic [31:0]         rdata_q;

  logic [NUM_ROMS-1:0] rom_dec;
  logic [NUM_RAMS-1:0] ram_dec;
  logic                dec_mapped;
  logic                host_req;
  logic                sel_ack;
  logic [31:0]         sel_data;
  logic                tmo_hit;

  assign host_req = host.wb_cyc_i & host.wb_strobe_i;

  // Decode of the address being latched; the one-hot result is registered
  // straight into the strobe flops so REQ needs no further decode.
  always_comb begin
    rom_dec = '0;
    ram_dec = '0;
    for (int k = 0; k < NUM_ROMS; k++) begin
      rom_dec[k] = (host.wb_addr_i[17:16] == 2'd0) && (host.wb_addr_i[13:10] == 4'(k));
    end
    for (int k = 0; k < NUM_RAMS; k++) begin
      ram_dec[k] = (host.wb_addr_i[17:16] == 2'd1) && (host.wb_addr_i[12:9] == 4'(k));
    end
    dec_mapped = (|rom_dec) | (|ram_dec);
  end

  // Only the strobed slave can complete the transfer; masking acks and data
  // with the one-hot strobe ignores everyone else.
  always_comb begin
    sel_ack  = (|(rom_ack_i & rom_stb_q)) | (|(ram_ack_i & ram_stb_q));
    sel_data = '0;
    for (int k = 0; k < NUM_ROMS; k++) begin
      if (rom_stb_q[k]) sel_data = sel_data | rom_data_i[32*k +: 32];
    end
    for (int k = 0; k < NUM_RAMS; k++) begin
      if (ram_stb_q[k]) sel_data = sel_data | ram_data_i[32*k +: 32];
    end
  end

`ifdef WB_BUS_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  // Counts cycles spent in REQ; held at zero elsewhere so REQ entry starts at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= 8'd0;
    end else if (state_q == ST_REQ) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end else begin
      tmo_cnt_q <= 8'd0;
    end
  end

  assign tmo_hit = (tmo_cnt_q == 8'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  // Transfer sequencer: latch, strobe one slave, capture its response, reply once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      rom_stb_q <= '0;
      ram_stb_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          if (host_req) begin
            addr_q    <= host.wb_addr_i;
            wdata_q   <= host.wb_data_i;
            we_q      <= host.wb_we_i;
            rom_stb_q <= rom_dec;
            ram_stb_q <= ram_dec;
            if (dec_mapped) begin
              cyc_q   <= 1'b1;
              state_q <= ST_REQ;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end

        ST_REQ: begin
          if (!host.wb_cyc_i) begin
            // Host abandoned the cycle: withdraw silently.
            cyc_q     <= 1'b0;
            rom_stb_q <= '0;
            ram_stb_q <= '0;
            state_q   <= ST_IDLE;
          end else if (sel_ack) begin
            // Ack beats timeout expiry in the same cycle.
            cyc_q     <= 1'b0;
            rom_stb_q <= '0;
            ram_stb_q <= '0;
            ack_q     <= 1'b1;
            rdata_q   <= we_q ? 32'd0 : sel_data;
            state_q   <= ST_RESP;
          end else if (tmo_hit) begin
            cyc_q     <= 1'b0;
            rom_stb_q <= '0;
            ram_stb_q <= '0;
            err_q     <= 1'b1;
            state_q   <= ST_RESP;
          end
        end

        ST_RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          cyc_q     <= 1'b0;
          rom_stb_q <= '0;
          ram_stb_q <= '0;
          ack_q     <= 1'b0;
          err_q     <= 1'b0;
          rdata_q   <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_addr_o       = addr_q;
  assign s_data_o       = wdata_q;
  assign s_we_o         = we_q;
  assign s_cyc_o        = cyc_q;
  assign rom_strobe_o   = rom_stb_q;
  assign ram_strobe_o   = ram_stb_q;
  assign host.wb_ack_o  = ack_q;
  assign host.wb_err_o  = err_q;
  assign host.wb_data_o = rdata_q;

endmodule

// File: tb/tb_wb_chip_bus.sv
// Scoreboard bench for wb_chip_bus: stimulus pushes expected host responses,
// a negedge monitor pops and compares whenever ack or err is presented.
module tb_wb_chip_bus;
  localparam int NR  = 1;
  localparam int NM  = 2;
  localparam int TMO = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  wb_chip_bus_if host ();

  logic [31:0]      s_addr, s_data;
  logic             s_we, s_cyc;
  logic [NR-1:0]    rom_stb, rom_ack;
  logic [NM-1:0]    ram_stb, ram_ack;
  logic [32*NR-1:0] rom_data;
  logic [32*NM-1:0] ram_data;

  wb_chip_bus #(.NUM_ROMS(NR), .NUM_RAMS(NM), .TIMEOUT_CYCLES(TMO)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .host         (host),
    .s_addr_o     (s_addr),
    .s_data_o     (s_data),
    .s_we_o       (s_we),
    .s_cyc_o      (s_cyc),
    .rom_strobe_o (rom_stb),
    .ram_strobe_o (ram_stb),
    .rom_data_i   (rom_data),
    .rom_ack_i    (rom_ack),
    .ram_data_i   (ram_data),
    .ram_ack_i    (ram_ack)
  );

  typedef struct {
    bit          err;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave responder: acks the strobed slave 'dly' cycles after strobe appears.
  int dly = 1;
  bit silent = 1'b0;
  bit spurious = 1'b0;
  int rcnt = 0;

  initial begin
    rom_data = 32'h0000_00A5;
    ram_data = {32'h2222_0001, 32'h1111_0000};
    rom_ack  = '0;
    ram_ack  = '0;
    forever begin
      @(posedge clock);
      #1;
      if ((|rom_stb) || (|ram_stb)) begin
        rom_ack = (rcnt == dly && !silent) ? rom_stb : '0;
        ram_ack = (rcnt == dly && !silent) ? ram_stb : '0;
        rcnt++;
      end else begin
        rom_ack = '0;
        ram_ack = '0;
        rcnt    = 0;
      end
      if (spurious) rom_ack[0] = 1'b1;
    end
  end

  // Monitor: every presented response must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && (host.wb_ack_o || host.wb_err_o)) begin
        check("ack_err_exclusive", 64'(host.wb_ack_o & host.wb_err_o), 64'(0));
        if (sb.size() == 0) begin
          check("unexpected_response", 64'({host.wb_ack_o, host.wb_err_o}), 64'(0));
        end else begin
          e = sb.pop_front();
          check({e.name, "_resp"}, 64'({host.wb_err_o, host.wb_ack_o, host.wb_data_o}),
                64'({e.err, ~e.err, e.data}));
        end
      end
    end
  end

  task automatic host_idle();
    host.wb_cyc_i    = 1'b0;
    host.wb_strobe_i = 1'b0;
    host.wb_we_i     = 1'b0;
  endtask

  task automatic host_start(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    host.wb_addr_i   = addr;
    host.wb_data_i   = wdata;
    host.wb_we_i     = we;
    host.wb_cyc_i    = 1'b1;
    host.wb_strobe_i = 1'b1;
  endtask

  // One host transfer; exp_lat is the cycle of the host response counting the
  // strobe-sampling cycle as 0.
  task automatic xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic we, input logic exp_err, input logic [31:0] exp_data,
                      input logic [NR-1:0] exp_rom, input logic [NM-1:0] exp_ram,
                      input int exp_lat);
    exp_t e;
    int   lat;
    bit   done;
    logic mapped;
    mapped = (|exp_rom) | (|exp_ram);
    e.err  = exp_err;
    e.data = exp_data;
    e.name = name;
    sb.push_back(e);
    @(posedge clock);
    #1;
    host_start(addr, wdata, we);
    @(negedge clock);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        check({name, "_strobes"}, 64'({s_cyc, rom_stb, ram_stb}), 64'({mapped, exp_rom, exp_ram}));
        if (mapped) begin
          check({name, "_s_addr"}, 64'(s_addr), 64'(addr));
          check({name, "_s_we_data"}, 64'({s_we, s_data}), 64'({we, wdata}));
        end
      end
      if (host.wb_ack_o || host.wb_err_o) done = 1'b1;
    end
    check({name, "_latency"}, done ? 64'(lat) : 64'(-1), 64'(exp_lat));
    host_idle();
  endtask

  initial begin
    host.wb_addr_i = '0;
    host.wb_data_i = '0;
    host_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_ctrl", 64'({s_cyc, rom_stb, ram_stb, s_we, host.wb_ack_o, host.wb_err_o}), 64'(0));
    check("reset_bus", 64'({s_addr, s_data}), 64'(0));
    check("reset_rdata", 64'(host.wb_data_o), 64'(0));
    reset_n = 1'b1;

    dly = 1;
    xfer("rom_read",   32'h0000_0004, 32'h0, 1'b0, 1'b0, 32'h0000_00A5, 1'b1, 2'b00, 3);
    xfer("ram1_write", 32'h0001_0200, 32'h7, 1'b1, 1'b0, 32'h0,         1'b0, 2'b10, 3);
    dly = 0;
    xfer("ram0_read",  32'h0001_0000, 32'h0, 1'b0, 1'b0, 32'h1111_0000, 1'b0, 2'b01, 2);
    xfer("ram1_read",  32'h0001_0200, 32'h0, 1'b0, 1'b0, 32'h2222_0001, 1'b0, 2'b10, 2);

    xfer("unmap_region", 32'h0002_0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 1);
    xfer("unmap_ram_idx", 32'h0001_0400, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 1);
    xfer("unmap_rom_idx", 32'h0000_0400, 32'h5, 1'b1, 1'b1, 32'h0, 1'b0, 2'b00, 1);
    xfer("unmap_region3", 32'h0003_0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 1);

    dly = 3;
    spurious = 1'b1;
    xfer("spurious_rom_ack", 32'h0001_0000, 32'h0, 1'b0, 1'b0, 32'h1111_0000, 1'b0, 2'b01, 5);
    spurious = 1'b0;

    // Host abort while the slave stays silent.
    silent = 1'b1;
    @(posedge clock);
    #1;
    host_start(32'h0001_0000, 32'h0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("abort_strobe_up", 64'({s_cyc, ram_stb}), 64'(3'b101));
    host_idle();
    @(negedge clock);
    check("abort_strobe_drop", 64'({s_cyc, rom_stb, ram_stb, host.wb_ack_o, host.wb_err_o}), 64'(0));
    repeat (3) @(negedge clock);
    check("abort_quiet", 64'({s_cyc, host.wb_ack_o, host.wb_err_o}), 64'(0));
    silent = 1'b0;
    dly = 1;
    xfer("after_abort", 32'h0000_0008, 32'h0, 1'b0, 1'b0, 32'h0000_00A5, 1'b1, 2'b00, 3);

    // Reset asserted mid-REQ clears outputs without waiting for a clock edge.
    silent = 1'b1;
    @(posedge clock);
    #1;
    host_start(32'h0001_0200, 32'h0000_1234, 1'b1);
    @(negedge clock);
    @(negedge clock);
    check("rst_mid_strobe_up", 64'({s_cyc, ram_stb}), 64'(3'b110));
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({s_cyc, rom_stb, ram_stb, s_we, host.wb_ack_o, host.wb_err_o}), 64'(0));
    check("rst_mid_bus", 64'({s_addr, s_data}), 64'(0));
    host_idle();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    silent = 1'b0;
    dly = 2;
    xfer("after_reset", 32'h0001_0200, 32'h0, 1'b0, 1'b0, 32'h2222_0001, 1'b0, 2'b10, 4);

`ifdef WB_BUS_TIMEOUT_EN
    silent = 1'b1;
    xfer("timeout_err", 32'h0000_0004, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 2'b00, TMO + 2);
    silent = 1'b0;
    dly = TMO;
    xfer("expiry_ack_wins", 32'h0000_0004, 32'h0, 1'b0, 1'b0, 32'h0000_00A5, 1'b1, 2'b00, TMO + 2);
`endif

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
